dbg_frame_streamer: RTL

Parametrised debug frame generator that drives the UART transmit path in `fpga_template_comm`. Each of `NUM_TRIG` raw trigger inputs (buttons or internal strobes) is synchronised and debounced. A qualified rising edge queues a framed ASCII/binary message, which is streamed byte by byte over a valid/ready handshake. The block replaces fixed-delay byte timing with handshake pacing, adds multi-channel arbitration, configurable payload length and an inter-byte gap, and reports a sticky timeout error.

---
 rtl/dbg_frame_streamer_pkg.sv | 55 +++++
 rtl/dbg_frame_streamer_trig_debounce.sv | 64 ++++++
 rtl/dbg_frame_streamer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/dbg_frame_streamer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dbg_frame_streamer_pkg                                          |
// | Purpose  : Shared types and constants for the debug frame streamer:       |
// |            FSM state encoding, ASCII header/trailer bytes and a helper    |
// |            that maps a byte index within a frame to the byte value.       |
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package dbg_frame_streamer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    GAP  = 2'd3
  } dbg_state_t;

  localparam logic [7:0] DBG_HDR_D     = 8'h44;  // 'D'
  localparam logic [7:0] DBG_HDR_B     = 8'h42;  // 'B'
  localparam logic [7:0] DBG_HDR_G     = 8'h47;  // 'G'
  localparam logic [7:0] DBG_HDR_CH0   = 8'h30;  // '0', channel digit base
  localparam logic [7:0] DBG_HDR_COLON = 8'h3A;  // ':'
  localparam logic [7:0] DBG_HDR_SPACE = 8'h20;  // ' '
  localparam logic [7:0] DBG_CR        = 8'h0D;
  localparam logic [7:0] DBG_LF        = 8'h0A;

  localparam int DBG_HDR_LEN = 6;
  localparam int DBG_TRL_LEN = 2;

  // Byte at position idx of a frame: 6 header bytes, plen payload bytes
  // counting up from base (8-bit wrap), then CR LF.
  function automatic logic [7:0] dbg_frame_byte(
    input logic [8:0] idx,
    input logic [7:0] ch,
    input logic [7:0] base,
    input logic [8:0] plen
  );
    logic [8:0] pidx;
    logic [8:0] tidx;
    pidx = idx - 9'(DBG_HDR_LEN);
    tidx = pidx - plen;
    if (idx == 9'd0)      return DBG_HDR_D;
    else if (idx == 9'd1) return DBG_HDR_B;
    else if (idx == 9'd2) return DBG_HDR_G;
    else if (idx == 9'd3) return DBG_HDR_CH0 + ch;
    else if (idx == 9'd4) return DBG_HDR_COLON;
    else if (idx == 9'd5) return DBG_HDR_SPACE;
    else if (pidx < plen) return base + pidx[7:0];
    else if (tidx == 9'd0) return DBG_CR;
    else                  return DBG_LF;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dbg_frame_streamer_trig_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dbg_frame_streamer_trig_debounce                                |
// | Purpose  : Conditions one raw trigger: 2-flop synchroniser, debounce      |
// |            counter and a one-cycle pulse on a rising edge of the          |
// |            debounced (stable) level.                                      |
// | Ports    : clk    - system clock                                           |
// |            resetb - asynchronous active-low reset                          |
// |            din    - raw asynchronous trigger input                         |
// |            rise   - one-cycle pulse when the stable level goes 0 -> 1      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module dbg_frame_streamer_trig_debounce #(
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic clk,
  input  logic resetb,
  input  logic din,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic             stable;
  logic             stable_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= din;
      sync_q2 <= sync_q1;
    end
  end

  // cnt holds how many consecutive samples have disagreed with the stable
  // level; the sample that would make it DEBOUNCE_CYCLES flips the level.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      cnt      <= '0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
    end else begin
      stable_d <= stable;
      if (sync_q2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt    <= '0;
        stable <= sync_q2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign rise = stable & ~stable_d;

endmodule
`default_nettype wire

// File: rtl/dbg_frame_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dbg_frame_streamer                                              |
// | Purpose  : Multi-channel debug frame generator. Each debounced trigger    |
// |            rising edge queues a "DBGn: <payload>\r\n" frame which is      |
// |            streamed byte by byte over a valid/ready handshake with an     |
// |            optional inter-byte gap and a sticky handshake timeout flag.   |
// | Ports    : clk          - system clock                                     |
// |            resetb       - asynchronous active-low reset                    |
// |            trig_in      - raw trigger inputs, one per channel              |
// |            payload_base - first payload byte, sampled at frame start       |
// |            tx_ready     - downstream can accept a byte                     |
// |            tx_valid     - tx_data holds a byte to transmit                 |
// |            tx_data      - byte to transmit                                 |
// |            busy         - a frame is in progress                           |
// |            active_ch    - channel of the current or last frame             |
// |            err_timeout  - sticky handshake timeout flag                    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module dbg_frame_streamer
  import dbg_frame_streamer_pkg::*;
#(
  parameter  int NUM_TRIG        = 2,
  parameter  int DEBOUNCE_CYCLES = 270000,
  parameter  int PAYLOAD_LEN     = 16,
  parameter  int GAP_CYCLES      = 16,
  parameter  int TIMEOUT_CYCLES  = 65535,
  localparam int CH_W            = (NUM_TRIG > 1) ? $clog2(NUM_TRIG) : 1
) (
  input  logic                clk,
  input  logic                resetb,
  input  logic [NUM_TRIG-1:0] trig_in,
  input  logic [7:0]          payload_base,
  input  logic                tx_ready,
  output logic                tx_valid,
  output logic [7:0]          tx_data,
  output logic                busy,
  output logic [CH_W-1:0]     active_ch,
  output logic                err_timeout
);

  localparam int FRAME_LEN = DBG_HDR_LEN + PAYLOAD_LEN + DBG_TRL_LEN;
  localparam logic [8:0] LAST_IDX = 9'(FRAME_LEN - 1);
  localparam logic [8:0] PLEN     = 9'(PAYLOAD_LEN);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST =
      (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  dbg_state_t          state;
  dbg_state_t          state_nxt;
  logic [NUM_TRIG-1:0] rise;
  logic [NUM_TRIG-1:0] pending;
  logic [NUM_TRIG-1:0] grant_mask;
  logic [CH_W-1:0]     grant_ch;
  logic                any_pending;
  logic                take;
  logic [8:0]          byte_idx;
  logic [7:0]          base_q;
  logic [GAP_W-1:0]    gap_cnt;
  logic [TO_W-1:0]     wait_cnt;
  logic                accept;
  logic                last_byte;
  logic                gap_done;
  logic                timeout;

  // --------------------------------------------------------------------------
  // Input conditioning, one debouncer per channel
  // --------------------------------------------------------------------------
  generate
    for (genvar g = 0; g < NUM_TRIG; g++) begin : g_trig
      dbg_frame_streamer_trig_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
        .clk   (clk),
        .resetb(resetb),
        .din   (trig_in[g]),
        .rise  (rise[g])
      );
    end
  endgenerate

  // Lowest pending index wins: scan downwards so the lowest hit is kept.
  always_comb begin
    grant_mask  = '0;
    grant_ch    = '0;
    any_pending = |pending;
    for (int i = NUM_TRIG - 1; i >= 0; i--) begin
      if (pending[i]) begin
        grant_mask    = '0;
        grant_mask[i] = 1'b1;
        grant_ch      = CH_W'(i);
      end
    end
  end

  assign take      = (state == IDLE) && any_pending;
  assign accept    = (state == SEND) && tx_ready;
  assign last_byte = (byte_idx == LAST_IDX);
  assign gap_done  = (gap_cnt == GAP_LAST);
  assign timeout   = (state == SEND) && !tx_ready && (wait_cnt == TO_LAST);

  // An edge on a channel that is already pending is absorbed by the OR; the
  // granted bit is cleared in the same cycle, dropping a coincident edge too.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      pending <= '0;
    end else begin
      pending <= (pending | rise) & ~(take ? grant_mask : '0);
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (any_pending) state_nxt = LOAD;
      LOAD: state_nxt = SEND;
      SEND: begin
        if (accept) begin
          if (last_byte)            state_nxt = IDLE;
          else if (GAP_CYCLES == 0) state_nxt = SEND;
          else                      state_nxt = GAP;
        end else if (timeout) begin
          state_nxt = IDLE;
        end
      end
      GAP:  if (gap_done) state_nxt = SEND;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    busy     = 1'b1;
    case (state)
      IDLE: busy = 1'b0;
      SEND: begin
        tx_valid = 1'b1;
        tx_data  = dbg_frame_byte(byte_idx, 8'(active_ch), base_q, PLEN);
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Frame datapath: byte index, gap and handshake-wait counters, latches
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      active_ch   <= '0;
      base_q      <= 8'h00;
      err_timeout <= 1'b0;
      byte_idx    <= '0;
      gap_cnt     <= '0;
      wait_cnt    <= '0;
    end else begin
      if (take) begin
        active_ch   <= grant_ch;
        base_q      <= payload_base;
        err_timeout <= 1'b0;
      end
      if (state == LOAD) begin
        byte_idx <= '0;
        wait_cnt <= '0;
      end
      if (state == SEND) begin
        if (accept) begin
          byte_idx <= byte_idx + 1'b1;
          wait_cnt <= '0;
          gap_cnt  <= '0;
        end else if (timeout) begin
          err_timeout <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
      end
      if (state == GAP) begin
        gap_cnt <= gap_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
